// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding and BCD constants.
// Also holds the nibble legality test used at operand acceptance.
package bcd_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic logic nibble_bad(input logic [3:0] n);
        return (n > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Single-digit BCD adder: binary add of two digits plus carry, then decimal correction.
module bcd_digit_add
    import bcd_serial_add_ctrl_pkg::*;
(
    output logic [3:0] digit,
    output logic       carry,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin
);

    logic [4:0] w_bin;
    logic [3:0] w_corr;

    assign w_bin  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    assign carry  = (w_bin > {1'b0, BCD_MAX});
    // Adding 6 modulo 16 skips the six unused codes and lands on the decimal digit
    assign w_corr = w_bin[3:0] + BCD_CORR;
    assign digit  = carry ? w_corr : w_bin[3:0];

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per cycle, LSD first, through a shared digit adder.
// Operands with an illegal nibble are rejected straight to DONE with err set.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                c_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                c_out,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_err;
    logic             r_done;

    int               w_base;
    logic [3:0]       w_x;
    logic [3:0]       w_y;
    logic [3:0]       w_digit;
    logic             w_dcarry;

    function automatic logic has_bad_nibble(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (nibble_bad(v[4*i +: 4])) bad = 1'b1;
        end
        return bad;
    endfunction

    assign w_base = 4 * int'(r_idx);
    assign w_x    = r_a[w_base +: 4];
    assign w_y    = r_b[w_base +: 4];

    bcd_digit_add u_digit_add (
        .digit (w_digit),
        .carry (w_dcarry),
        .x     (w_x),
        .y     (w_y),
        .cin   (r_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        if (has_bad_nibble(a) || has_bad_nibble(b)) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= ST_ADD;
                        end
                    end
                end
                ST_ADD: begin
                    r_sum[w_base +: 4] <= w_digit;
                    r_carry            <= w_dcarry;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_dcarry;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = r_done;
    assign sum   = r_sum;
    assign c_out = r_cout;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomised and directed bench for the digit-serial BCD adder against a decimal-arithmetic model.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0;
    logic [15:0] a4 = '0;
    logic [15:0] b4 = '0;
    logic        cin4 = 1'b0;
    logic        busy4, done4, cout4, err4;
    logic [15:0] sum4;

    logic        start1 = 1'b0;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        busy1, done1, cout1, err1;
    logic [3:0]  sum1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .err(err4)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .err(err1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: decode both operands to integers, add, re-encode.
    function automatic void model4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   output logic [15:0] s, output logic co, output logic e);
        longint va, vb, t, lim;
        va = 0; vb = 0; lim = 1; e = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) e = 1'b1;
            va  = va * 10 + longint'(a[4*i +: 4]);
            vb  = vb * 10 + longint'(b[4*i +: 4]);
            lim = lim * 10;
        end
        s = '0; co = 1'b0;
        if (!e) begin
            t  = va + vb + longint'(cin);
            co = (t >= lim);
            t  = t % lim;
            for (int i = 0; i < D; i++) begin
                s[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input bit poke, input bit scramble);
        logic [15:0] es;
        logic        eco, ee;
        int          k;
        bit          found;
        model4(a, b, cin, es, eco, ee);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        if (scramble) begin
            a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        end
        k = 0; found = 1'b0;
        while (!found && k < 40) begin
            if (done4) found = 1'b1;
            else begin
                if (k == 0) chk("busy_in_add", busy4, 1);
                if (poke && k == 2) begin
                    start4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b1;
                end
                @(posedge clk); #1;
                start4 = 1'b0;
                k++;
            end
        end
        chk("done_seen", found, 1);
        chk("latency", k + 1, ee ? 1 : D + 1);
        chk("sum", sum4, es);
        chk("c_out", cout4, eco);
        chk("err", err4, ee);
        @(posedge clk); #1;
        chk("done_one_cycle", done4, 0);
        chk("idle_after", busy4, 0);
        chk("sum_held", sum4, es);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c, pulses, last_c;
        bit          any_done;
        logic [15:0] ra, rb;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_sum", sum4, 0);
        chk("rst_cout", cout4, 0);
        chk("rst_err", err4, 0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        run_op(16'h1234, 16'h8766, 1'b0, 0, 0);
        run_op(16'h9999, 16'h0000, 1'b1, 0, 0);
        run_op(16'h0505, 16'h0404, 1'b0, 0, 0);
        run_op(16'h0A00, 16'h0001, 1'b0, 0, 0);
        run_op(16'h0012, 16'h0034, 1'b0, 0, 0);
        run_op(16'h9999, 16'h9999, 1'b1, 0, 0);
        run_op(16'h4321, 16'h1234, 1'b1, 1, 0);
        run_op(16'h5555, 16'h4444, 1'b1, 0, 1);

        // Randomised operations with illegal nibbles, input churn and ignored starts mixed in
        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 5) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            run_op(ra, rb, 1'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Start held high: back-to-back operations every D+2 cycles
        @(negedge clk);
        a4 = 16'h2468; b4 = 16'h1357; cin4 = 1'b0; start4 = 1'b1;
        c = 0; pulses = 0; last_c = 0;
        while (pulses < 3 && c < 60) begin
            @(posedge clk); #1;
            c++;
            if (done4) begin
                chk("b2b_sum", sum4, 16'h3825);
                if (pulses > 0) chk("b2b_period", c - last_c, D + 2);
                last_c = c;
                pulses++;
                if (pulses == 3) start4 = 1'b0;
            end
        end
        chk("b2b_pulses", pulses, 3);
        @(posedge clk); #1;
        chk("b2b_idle", busy4, 0);

        // Reset in the middle of ADD aborts without a done pulse
        @(negedge clk);
        a4 = 16'h1234; b4 = 16'h1111; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_sum", sum4, 0);
        chk("abort_cout", cout4, 0);
        chk("abort_err", err4, 0);
        any_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done4) any_done = 1'b1;
        end
        chk("abort_no_done", any_done, 0);
        run_op(16'h0999, 16'h0001, 1'b0, 0, 0);

        // Exhaustive single-digit sweep on the one-digit instance
        for (int x = 0; x < 10; x++) begin
            for (int y = 0; y < 10; y++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int k1, tot;
                    @(negedge clk);
                    a1 = 4'(x); b1 = 4'(y); cin1 = 1'(ci); start1 = 1'b1;
                    @(posedge clk); #1; start1 = 1'b0;
                    k1 = 0;
                    while (!done1 && k1 < 10) begin
                        @(posedge clk); #1;
                        k1++;
                    end
                    tot = x + y + ci;
                    chk("sweep_lat", k1 + 1, 2);
                    chk("sweep_sum", {cout1, sum1}, {tot >= 10, 4'(tot % 10)});
                    @(posedge clk); #1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
